// File: rtl/packet_splitter.sv
// rtl/packet_splitter.sv - queues 68-bit routed packets and serialises each into four 17-bit-data flits
module packet_splitter #(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int QUEUE_DEPTH     = 4,
    localparam int NODE_W = $clog2(NODE_COUNT),
    localparam int ID_W   = PACKET_ID_WIDTH,
    localparam int FW     = 1 + 2*NODE_W + ID_W + 17 + 2,
    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [67:0]       packet_in,
    input  logic [NODE_W-1:0] node_start_in,
    input  logic [NODE_W-1:0] node_dest_in,
    input  logic [ID_W-1:0]   packet_id_in,
    output logic [FW-1:0]     flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [CNT_W-1:0]  queue_count,
    output logic              busy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t state, state_nxt;

    // Packet queue storage and bookkeeping
    logic [67:0]       q_pkt   [QUEUE_DEPTH];
    logic [NODE_W-1:0] q_start [QUEUE_DEPTH];
    logic [NODE_W-1:0] q_dest  [QUEUE_DEPTH];
    logic [ID_W-1:0]   q_id    [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    // In-flight packet: the flits still to be presented after the current one
    logic [1:0]        idx;
    logic [50:0]       rest;
    logic [NODE_W-1:0] cur_start, cur_dest;
    logic [ID_W-1:0]   cur_id;
    logic [FW-1:0]     flit_q;
    logic              flit_valid_q;

    logic full, empty, push, take;
    logic load, advance, finish, pop, bypass, wr;
    logic [67:0]       src_pkt;
    logic [NODE_W-1:0] src_start, src_dest;
    logic [ID_W-1:0]   src_id;

    assign full      = (count == CNT_W'(QUEUE_DEPTH));
    assign empty     = (count == '0);
    assign ready_out = !full;
    assign push      = valid_in && ready_out && ce;
    assign take      = flit_valid_q && flit_ready && ce;

    // A packet arriving at an idle, empty block is loaded straight into the
    // serialiser so its first flit appears on the very next cycle.
    assign bypass = load && empty;
    assign pop    = load && !empty;
    assign wr     = push && !bypass;

    assign src_pkt   = empty ? packet_in     : q_pkt[rd_ptr];
    assign src_start = empty ? node_start_in : q_start[rd_ptr];
    assign src_dest  = empty ? node_dest_in  : q_dest[rd_ptr];
    assign src_id    = empty ? packet_id_in  : q_id[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE when a packet is available, return after the last flit if nothing waits
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ce && (!empty || push)) state_nxt = S_SEND;
            S_SEND: if (take && idx == 2'd3 && empty) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode: load a new packet, step to the next flit, or drop flit_valid
    always_comb begin
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: load = ce && (!empty || push);
            S_SEND: begin
                if (take) begin
                    if (idx != 2'd3) advance = 1'b1;
                    else if (!empty) load = 1'b1;
                    else finish = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(wr) - CNT_W'(pop);
        end
    end

    // Queue entry storage; contents are meaningless until written so no reset is needed
    always_ff @(posedge clk) begin
        if (wr) begin
            q_pkt[wr_ptr]   <= packet_in;
            q_start[wr_ptr] <= node_start_in;
            q_dest[wr_ptr]  <= node_dest_in;
            q_id[wr_ptr]    <= packet_id_in;
        end
    end

    // Serialiser: registered flit word, shifted payload and routing fields of the in-flight packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            rest         <= '0;
            cur_start    <= '0;
            cur_dest     <= '0;
            cur_id       <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else if (load) begin
            idx          <= 2'd0;
            rest         <= src_pkt[50:0];
            cur_start    <= src_start;
            cur_dest     <= src_dest;
            cur_id       <= src_id;
            flit_q       <= {1'b1, src_dest, src_pkt[67:51], src_id, src_start, 2'd0};
            flit_valid_q <= 1'b1;
        end else if (advance) begin
            idx          <= idx + 2'd1;
            rest         <= {rest[33:0], 17'd0};
            flit_q       <= {1'b1, cur_dest, rest[50:34], cur_id, cur_start, idx + 2'd1};
        end else if (finish) begin
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end
    end

    assign flit_out    = flit_q;
    assign flit_valid  = flit_valid_q;
    assign queue_count = count;
    assign busy        = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_packet_splitter.sv
// tb/tb_packet_splitter.sv - self-checking bench for packet_splitter
module tb_packet_splitter;

    localparam int NODE_W = 3;
    localparam int ID_W   = 5;
    localparam int FW     = 31;
    localparam int CNT_W  = 3;
    localparam int NVEC   = 8;

    logic              clk;
    logic              rst_n;
    logic              ce;
    logic              valid_in;
    logic              ready_out;
    logic [67:0]       packet_in;
    logic [NODE_W-1:0] node_start_in;
    logic [NODE_W-1:0] node_dest_in;
    logic [ID_W-1:0]   packet_id_in;
    logic [FW-1:0]     flit_out;
    logic              flit_valid;
    logic              flit_ready;
    logic [CNT_W-1:0]  queue_count;
    logic              busy;

    packet_splitter #(.NODE_COUNT(8), .PACKET_ID_WIDTH(5), .QUEUE_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .packet_in     (packet_in),
        .node_start_in (node_start_in),
        .node_dest_in  (node_dest_in),
        .packet_id_in  (packet_id_in),
        .flit_out      (flit_out),
        .flit_valid    (flit_valid),
        .flit_ready    (flit_ready),
        .queue_count   (queue_count),
        .busy          (busy)
    );

    typedef struct {
        logic [67:0]        pkt;
        logic [NODE_W-1:0]  start;
        logic [NODE_W-1:0]  dest;
        logic [ID_W-1:0]    id;
        logic [0:3][16:0]   exp;
    } vec_t;

    vec_t vec [NVEC];
    logic [FW-1:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic [16:0] d0, input logic [16:0] d1,
                           input logic [16:0] d2, input logic [16:0] d3,
                           input logic [2:0] s, input logic [2:0] d, input logic [4:0] id);
        vec[k].pkt   = {d0, d1, d2, d3};
        vec[k].exp   = {d0, d1, d2, d3};
        vec[k].start = s;
        vec[k].dest  = d;
        vec[k].id    = id;
    endtask

    function automatic logic [FW-1:0] mkflit(input int k, input int i);
        logic [1:0] ii;
        ii = 2'(i);
        return {1'b1, vec[k].dest, vec[k].exp[i], vec[k].id, vec[k].start, ii};
    endfunction

    // Scoreboard consumer: every taken flit must match the oldest expected flit
    always @(negedge clk) begin
        if (rst_n) begin
            if (flit_valid && flit_ready && ce) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_flit: got %0h expected none", flit_out);
                end else begin
                    check("flit", 68'(flit_out), 68'(sb.pop_front()));
                end
            end
            if (!flit_valid) check("flit_zero_when_invalid", 68'(flit_out), 68'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present vec[k] until accepted, then queue its four expected flits
    task automatic send_pkt(input int k);
        bit done;
        valid_in      = 1'b1;
        packet_in     = vec[k].pkt;
        node_start_in = vec[k].start;
        node_dest_in  = vec[k].dest;
        packet_id_in  = vec[k].id;
        done = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (ready_out && ce) begin
                done = 1;
                for (int i = 0; i < 4; i++) sb.push_back(mkflit(k, i));
            end else begin
                step();
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: packet %0d not accepted", k);
        end
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (!busy && !flit_valid) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b flit_valid=%0b", busy, flit_valid);
        end
        step();
    endtask

    logic [FW-1:0] cap;
    int run;

    initial begin
        set_vec(0, 17'h1AAAA, 17'h0BBBB, 17'h1CCCC, 17'h0DDDD, 3'd3, 3'd5, 5'd7);
        set_vec(1, 17'h00001, 17'h00002, 17'h00003, 17'h00004, 3'd0, 3'd7, 5'd1);
        set_vec(2, 17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h00000, 3'd7, 3'd0, 5'd31);
        set_vec(3, 17'h12345, 17'h0ABCD, 17'h1F00F, 17'h00F0F, 3'd1, 3'd2, 5'd10);
        set_vec(4, 17'h10000, 17'h08000, 17'h04000, 17'h00001, 3'd6, 3'd1, 5'd0);
        set_vec(5, 17'h15555, 17'h0AAAA, 17'h13C3C, 17'h0C3C3, 3'd2, 3'd4, 5'd19);
        set_vec(6, 17'h1E1E1, 17'h01E1E, 17'h1DEAD, 17'h0BEEF, 3'd5, 3'd6, 5'd22);
        set_vec(7, 17'h17777, 17'h06666, 17'h15555, 17'h04444, 3'd4, 3'd3, 5'd12);

        rst_n = 1'b0; ce = 1'b1; valid_in = 1'b0; flit_ready = 1'b0;
        packet_in = '0; node_start_in = '0; node_dest_in = '0; packet_id_in = '0;
        repeat (3) @(negedge clk);
        check("rst_flit_valid", 68'(flit_valid), 68'd0);
        check("rst_flit_out", 68'(flit_out), 68'd0);
        check("rst_queue_count", 68'(queue_count), 68'd0);
        check("rst_busy", 68'(busy), 68'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_out", 68'(ready_out), 68'd1);
        step();

        // T1: single packet, first flit on the cycle after acceptance
        flit_ready = 1'b1;
        send_pkt(0);
        @(negedge clk);
        check("t1_first_flit", 68'(flit_out), 68'({1'b1, 3'd5, 17'h1AAAA, 5'd7, 3'd3, 2'd0}));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", 68'(flit_valid), 68'd1);
            check("t1_idx", 68'(flit_out[1:0]), 68'(i));
        end
        @(negedge clk);
        check("t1_done", 68'(flit_valid), 68'd0);
        step();

        // Table: stream every vector back-to-back with the sink always ready
        for (int k = 0; k < NVEC; k++) send_pkt(k);
        wait_idle();
        check("table_sb_drained", 68'(sb.size()), 68'd0);

        // T2: backpressure on idx 1
        flit_ready = 1'b0;
        send_pkt(1);
        flit_ready = 1'b1;
        step();
        flit_ready = 1'b0;
        @(negedge clk);
        cap = flit_out;
        check("t2_idx1", 68'(flit_out[1:0]), 68'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("t2_stable", 68'(flit_out), 68'(cap));
        end
        step();
        flit_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t2_idx2_after_release", 68'(flit_out[1:0]), 68'd2);
        check("t2_valid_after_release", 68'(flit_valid), 68'd1);
        step();
        wait_idle();

        // T3: fill 1 in flight + 4 queued, then a 6th is refused
        flit_ready = 1'b0;
        for (int k = 2; k < 7; k++) send_pkt(k);
        @(negedge clk);
        check("t3_count_full", 68'(queue_count), 68'd4);
        check("t3_ready_low", 68'(ready_out), 68'd0);
        check("t3_busy", 68'(busy), 68'd1);
        check("t3_in_flight", 68'(flit_valid), 68'd1);
        step();
        valid_in = 1'b1; packet_in = vec[7].pkt; node_start_in = vec[7].start;
        node_dest_in = vec[7].dest; packet_id_in = vec[7].id;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_sixth_refused", 68'(ready_out), 68'd0);
            step();
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("t3_count_held", 68'(queue_count), 68'd4);
        step();
        flit_ready = 1'b1;
        wait_idle();
        check("t3_sb_drained", 68'(sb.size()), 68'd0);

        // T4: three queued packets drain as 12 consecutive flits
        flit_ready = 1'b0;
        for (int k = 5; k < 8; k++) send_pkt(k);
        flit_ready = 1'b1;
        run = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (flit_valid) run++;
            else if (run > 0) break;
        end
        check("t4_consecutive", 68'(run), 68'd12);
        step();
        check("t4_sb_drained", 68'(sb.size()), 68'd0);

        // T5: ce low mid-packet freezes everything, including a pending push
        flit_ready = 1'b0;
        send_pkt(3);
        flit_ready = 1'b1;
        step();
        ce = 1'b0;
        valid_in = 1'b1; packet_in = vec[4].pkt; node_start_in = vec[4].start;
        node_dest_in = vec[4].dest; packet_id_in = vec[4].id;
        @(negedge clk);
        cap = flit_out;
        check("t5_idx1", 68'(flit_out[1:0]), 68'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t5_frozen_flit", 68'(flit_out), 68'(cap));
            check("t5_no_push", 68'(queue_count), 68'd0);
        end
        step();
        ce = 1'b1;
        valid_in = 1'b0;
        wait_idle();
        check("t5_sb_drained", 68'(sb.size()), 68'd0);

        // T6: asynchronous reset while idx 2 is presented
        flit_ready = 1'b0;
        send_pkt(0);
        send_pkt(1);
        flit_ready = 1'b1;
        step();
        step();
        flit_ready = 1'b0;
        @(negedge clk);
        check("t6_idx2", 68'(flit_out[1:0]), 68'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_drop", 68'(flit_valid), 68'd0);
        check("t6_flit_zero", 68'(flit_out), 68'd0);
        check("t6_count", 68'(queue_count), 68'd0);
        check("t6_ready", 68'(ready_out), 68'd1);
        sb.delete();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        flit_ready = 1'b1;
        send_pkt(4);
        @(negedge clk);
        check("t6_restart_valid", 68'(flit_valid), 68'd1);
        check("t6_restart_idx0", 68'(flit_out[1:0]), 68'd0);
        step();
        wait_idle();
        check("final_sb_drained", 68'(sb.size()), 68'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
